pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline-stage register with stall,
// flush and bubble insertion, plus a saturating empty-slot counter.
// Optional build macro PIPE_STAGE_SKID_EN adds a second (skid) entry so that
// in_ready becomes a register with no combinational path from out_ready.
module pipe_stage_reg #(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] NOP_VAL    = {DATA_W{1'b0}},
    parameter bit                BUBBLE_CLR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       bubble_cnt
);

    // Main entry: this is what the downstream stage sees.
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [15:0]       bubble_cnt_q, bubble_cnt_d;

    logic up_xfer;
    logic down_xfer;

    // Stall freezes the stage, so out_ready is ignored and nothing drains.
    assign down_xfer = out_valid_q & out_ready & ~stall;
    assign up_xfer   = in_valid & in_ready;

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign bubble_cnt = bubble_cnt_q;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q,   in_ready_d;

    // Registered readiness; stall/flush still gate it so nothing is taken
    // while frozen or discarding. Reset value 0 keeps in_ready low in reset.
    assign in_ready = in_ready_q & ~stall & ~flush;

    // Next-state for main and skid entries; main always emits first.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_data_d   = NOP_VAL;
            skid_valid_d = 1'b0;
        end else if (down_xfer) begin
            if (skid_valid_q) begin
                // in_ready was low, so no upstream transfer can coincide.
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (up_xfer) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
                if (BUBBLE_CLR) begin
                    out_data_d = NOP_VAL;
                end
            end
        end else if (up_xfer) begin
            if (out_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    // Skid entry and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= NOP_VAL;
            in_ready_q   <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    // Single entry: a slot frees up in the same cycle the downstream takes it.
    assign in_ready = ~rst & ~stall & ~flush & (~out_valid_q | out_ready);

    // Next-state for the single entry: flush, then capture, then drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_data_d  = NOP_VAL;
        end else if (up_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else if (down_xfer) begin
            out_valid_d = 1'b0;
            if (BUBBLE_CLR) begin
                out_data_d = NOP_VAL;
            end
        end
    end
`endif

    // Count empty, unstalled cycles; stick at all-ones rather than wrap.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (~out_valid_q & ~stall & (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    // Main entry and bubble counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= NOP_VAL;
            bubble_cnt_q <= 16'd0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every
// negative edge, plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, stall, flush, out_valid, out_ready;
    logic [W-1:0]  in_data, out_data;
    logic [15:0]   bubble_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .bubble_cnt (bubble_cnt)
    );

    // Reference model: an ordered queue of held payloads.
    logic [W-1:0] mq[$];
    int           m_bub;
    bit           m_post_rst;
    bit           m_rdy, m_up, m_dn;

    function automatic bit m_in_ready();
`ifdef PIPE_STAGE_SKID_EN
        return !rst && !m_post_rst && (mq.size() < 2) && !stall && !flush;
`else
        return !rst && !stall && !flush && ((mq.size() == 0) || out_ready);
`endif
    endfunction

    function void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_bub      = 0;
            m_post_rst = 1'b1;
        end else begin
            m_rdy = m_in_ready();
            m_up  = in_valid && m_rdy;
            m_dn  = (mq.size() > 0) && out_ready && !stall;
            if ((mq.size() == 0) && !stall && (m_bub < 65535)) m_bub++;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_dn) void'(mq.pop_front());
                if (m_up) mq.push_back(in_data);
            end
            m_post_rst = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_out_valid", out_valid, (mq.size() > 0));
            chk("m_out_data", out_data, (mq.size() > 0) ? mq[0] : 32'h0);
            chk("m_in_ready", in_ready, m_in_ready());
            chk("m_bubble_cnt", bubble_cnt, m_bub);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] vals[3];
    logic [W-1:0] got[$];
    int           idx;
    bit           acc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_bub", bubble_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        tick(); tick();

        // Streaming 1..4 at full rate
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = i;
            #1;
            chk("stream_in_ready", in_ready, 1);
            tick();
            chk("stream_data", out_data, i);
            chk("stream_valid", out_valid, 1);
        end

        // Stall holds A5A5A5A5 and blocks the new word
        in_data = 32'hA5A5A5A5;
        tick();
        chk("stall_load", out_data, 32'hA5A5A5A5);
        stall = 1'b1; in_data = 32'h1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data", out_data, 32'hA5A5A5A5);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_bub", bubble_cnt, 3);
        end
        stall = 1'b0;
        tick();
        chk("unstall_data", out_data, 32'h1);
        chk("unstall_valid", out_valid, 1);

        // Flush overrides stall; incoming word dropped
        stall = 1'b1; flush = 1'b1; in_data = 32'd99;
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_data", out_data, 0);
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();

        // Backpressure with 5,6,7 then release
        vals[0] = 32'd5; vals[1] = 32'd6; vals[2] = 32'd7;
        idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (idx < 3);
            in_data   = (idx < 3) ? vals[idx] : 32'h0;
            @(negedge clk);
            if (out_valid && out_ready) got.push_back(out_data);
            acc = in_valid && in_ready;
`ifdef PIPE_STAGE_SKID_EN
            if (cyc == 1) chk("bp_ready_c1", in_ready, 1);
`else
            if (cyc == 1) chk("bp_ready_c1", in_ready, 0);
`endif
            if (cyc == 2) begin
                chk("bp_ready_c2", in_ready, 0);
                chk("bp_head_c2", out_data, 5);
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        chk("bp_count", got.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_order", (got.size() > i) ? got[i] : 32'hFFFF_FFFF, vals[i]);
        end

        // Asynchronous reset mid-cycle while holding DEADBEEF
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_data", out_data, 32'hDEADBEEF);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data", out_data, 0);
        chk("async_rst_bub", bubble_cnt, 0);
        chk("async_rst_ready", in_ready, 0);
        tick();
        rst = 1'b0;

        // Bubble counter count and saturation
        repeat (10) tick();
        chk("bub_10", bubble_cnt, 10);
        repeat (70000) tick();
        chk("bub_sat", bubble_cnt, 16'hFFFF);
        repeat (5) tick();
        chk("bub_hold", bubble_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
